// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//
// Round-robin arbiter for the single common data bus (CDB). Four execution
// queues (0 = int, 1 = mult, 2 = div, 3 = ldst) each present one completed
// result. At most one of them is granted per cycle. The granted payload is
// broadcast from registered CDB outputs on the following cycle.
//
// Ports
//   clk               rising-edge clock
//   rst               asynchronous active-low reset
//   flush             mispredict squash; blocks grant and broadcast this cycle
//   req_valid[i]      requester i holds a result
//   req_data          requester i result at [i*DATA_W +: DATA_W]
//   req_tag           requester i destination tag at [i*TAG_W +: TAG_W]
//   req_branch[i]     result is a branch
//   req_branch_taken  branch resolved taken
//   req_grant         one-hot (or zero); requester consumed at this edge
//   cdb_data/tag      registered broadcast payload
//   cdb_valid         registered broadcast valid
//   cdb_branch        registered broadcast branch flag
//   cdb_branch_taken  registered broadcast taken flag
// -----------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 6,
  parameter int NREQ   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*DATA_W-1:0] req_data,
  input  logic [NREQ*TAG_W-1:0]  req_tag,
  input  logic [NREQ-1:0]      req_branch,
  input  logic [NREQ-1:0]      req_branch_taken,
  output logic [NREQ-1:0]      req_grant,
  output logic [DATA_W-1:0]    cdb_data,
  output logic [TAG_W-1:0]     cdb_tag,
  output logic                 cdb_valid,
  output logic                 cdb_branch,
  output logic                 cdb_branch_taken
);

  // The pointer is exactly two bits wide so the mod-4 wrap is the natural
  // overflow of the addition; the arbiter only supports four requesters.
  logic [1:0]        ptr_q, ptr_d;
  logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
  logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic              cdb_valid_q, cdb_valid_d;
  logic              cdb_branch_q, cdb_branch_d;
  logic              cdb_branch_taken_q, cdb_branch_taken_d;

  logic [1:0] scan_idx;
  logic [1:0] win_idx;
  logic       win_found;
  logic       grant_vld;

  // Round-robin scan starting at the pointer; the first valid index wins.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write so
    // that no path leaves it unassigned and no latch is inferred.
    scan_idx  = ptr_q;
    win_idx   = ptr_q;
    win_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = ptr_q + 2'(k);
      if (!win_found && req_valid[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Flush beats any request; rst is included so the grant drops
  // asynchronously while the block is held in reset.
  assign grant_vld = win_found && !flush && rst;

  always_comb begin
    req_grant = '0;
    if (grant_vld) begin
      req_grant[win_idx] = 1'b1;
    end
  end

  // Next-state: load the winner's payload, or hold the payload and drop
  // valid. Consumers ignore stale payload while cdb_valid is low.
  always_comb begin
    ptr_d              = ptr_q;
    cdb_data_d         = cdb_data_q;
    cdb_tag_d          = cdb_tag_q;
    cdb_branch_d       = cdb_branch_q;
    cdb_branch_taken_d = cdb_branch_taken_q;
    cdb_valid_d        = 1'b0;
    if (grant_vld) begin
      ptr_d              = win_idx + 2'd1;
      cdb_data_d         = req_data[DATA_W*int'(win_idx) +: DATA_W];
      cdb_tag_d          = req_tag[TAG_W*int'(win_idx) +: TAG_W];
      cdb_branch_d       = req_branch[win_idx];
      cdb_branch_taken_d = req_branch_taken[win_idx];
      cdb_valid_d        = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge, independent of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q              <= '0;
      cdb_data_q         <= '0;
      cdb_tag_q          <= '0;
      cdb_valid_q        <= 1'b0;
      cdb_branch_q       <= 1'b0;
      cdb_branch_taken_q <= 1'b0;
    end else begin
      ptr_q              <= ptr_d;
      cdb_data_q         <= cdb_data_d;
      cdb_tag_q          <= cdb_tag_d;
      cdb_valid_q        <= cdb_valid_d;
      cdb_branch_q       <= cdb_branch_d;
      cdb_branch_taken_q <= cdb_branch_taken_d;
    end
  end

  assign cdb_data         = cdb_data_q;
  assign cdb_tag          = cdb_tag_q;
  assign cdb_valid        = cdb_valid_q;
  assign cdb_branch       = cdb_branch_q;
  assign cdb_branch_taken = cdb_branch_taken_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
//
// Directed bench for cdb_arbiter. Inputs change 1 ns after a rising edge;
// combinational grants are checked after a further 1 ns settle, registered
// CDB outputs 1 ns after the edge that loads them.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;

  localparam int DATA_W = 32;
  localparam int TAG_W  = 6;
  localparam int NREQ   = 4;

  logic                   clk;
  logic                   rst;
  logic                   flush;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ*TAG_W-1:0]  req_tag;
  logic [NREQ-1:0]        req_branch;
  logic [NREQ-1:0]        req_branch_taken;
  logic [NREQ-1:0]        req_grant;
  logic [DATA_W-1:0]      cdb_data;
  logic [TAG_W-1:0]       cdb_tag;
  logic                   cdb_valid;
  logic                   cdb_branch;
  logic                   cdb_branch_taken;

  int n_checks = 0;
  int n_fail   = 0;

  cdb_arbiter #(.DATA_W(DATA_W), .TAG_W(TAG_W), .NREQ(NREQ)) dut (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .req_valid        (req_valid),
    .req_data         (req_data),
    .req_tag          (req_tag),
    .req_branch       (req_branch),
    .req_branch_taken (req_branch_taken),
    .req_grant        (req_grant),
    .cdb_data         (cdb_data),
    .cdb_tag          (cdb_tag),
    .cdb_valid        (cdb_valid),
    .cdb_branch       (cdb_branch),
    .cdb_branch_taken (cdb_branch_taken)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [DATA_W-1:0] d, input logic [TAG_W-1:0] t,
                         input logic br, input logic tk);
    req_data[i*DATA_W +: DATA_W] = d;
    req_tag[i*TAG_W +: TAG_W]    = t;
    req_branch[i]                = br;
    req_branch_taken[i]          = tk;
  endtask

  initial begin
    rst              = 1'b0;
    flush            = 1'b0;
    req_valid        = 4'b1111;
    req_data         = '0;
    req_tag          = '0;
    req_branch       = '0;
    req_branch_taken = '0;
    for (int i = 0; i < NREQ; i++) begin
      set_req(i, 32'hA000_0000 + 32'(i), 6'(10 + i), 1'b0, 1'b0);
    end

    // Reset held with every requester valid, across a clock edge.
    tick();
    tick();
    check("rst_grant", 64'(req_grant), 64'h0);
    check("rst_valid", 64'(cdb_valid), 64'h0);
    check("rst_data",  64'(cdb_data),  64'h0);
    check("rst_tag",   64'(cdb_tag),   64'h0);
    check("rst_br",    64'(cdb_branch), 64'h0);

    // Release; full contention walks 0,1,2,3,0 with continuous valid.
    rst = 1'b1;
    #1;
    check("rel_grant0", 64'(req_grant), 64'b0001);
    tick();
    check("fc_valid0", 64'(cdb_valid), 64'h1);
    check("fc_data0",  64'(cdb_data),  64'hA000_0000);
    check("fc_tag0",   64'(cdb_tag),   64'd10);
    check("fc_grant1", 64'(req_grant), 64'b0010);
    tick();
    check("fc_tag1",   64'(cdb_tag),   64'd11);
    check("fc_grant2", 64'(req_grant), 64'b0100);
    tick();
    check("fc_tag2",   64'(cdb_tag),   64'd12);
    check("fc_grant3", 64'(req_grant), 64'b1000);
    tick();
    check("fc_tag3",   64'(cdb_tag),   64'd13);
    check("fc_valid3", 64'(cdb_valid), 64'h1);
    check("fc_grant4", 64'(req_grant), 64'b0001);
    tick();
    check("fc_tag4",   64'(cdb_tag),   64'd10);
    check("fc_data4",  64'(cdb_data),  64'hA000_0000);

    // Idle: no grant, valid drops, payload held. Pointer is 1.
    req_valid = 4'b0000;
    #1;
    check("idle_grant", 64'(req_grant), 64'h0);
    tick();
    check("idle_valid", 64'(cdb_valid), 64'h0);
    check("idle_hold",  64'(cdb_data),  64'hA000_0000);

    // Move pointer to 3 via a lone div grant, then wrap and skip.
    req_valid = 4'b0100;
    #1;
    check("pre_grant2", 64'(req_grant), 64'b0100);
    tick();
    req_valid = 4'b1010;
    #1;
    check("wrap_grant3", 64'(req_grant), 64'b1000);
    tick();
    check("wrap_tag3", 64'(cdb_tag), 64'd13);
    req_valid = 4'b0010;
    #1;
    check("wrap_grant1", 64'(req_grant), 64'b0010);
    tick();
    check("wrap_tag1", 64'(cdb_tag), 64'd11);

    // Pointer is 2; a lone ldst grant brings it back to 0.
    req_valid = 4'b1000;
    #1;
    tick();

    // Single requester: div with a new result, pointer 0.
    set_req(2, 32'hDEAD_BEEF, 6'd17, 1'b0, 1'b0);
    req_valid = 4'b0100;
    #1;
    check("single_grant", 64'(req_grant), 64'b0100);
    tick();
    req_valid = 4'b0000;
    check("single_data",  64'(cdb_data),   64'hDEAD_BEEF);
    check("single_tag",   64'(cdb_tag),    64'd17);
    check("single_valid", 64'(cdb_valid),  64'h1);
    check("single_br",    64'(cdb_branch), 64'h0);
    tick();
    check("single_drop", 64'(cdb_valid), 64'h0);

    // Branch: int taken branch wins from pointer 3.
    set_req(0, 32'h0000_0B0B, 6'd5, 1'b1, 1'b1);
    req_valid = 4'b0001;
    #1;
    check("br_grant", 64'(req_grant), 64'b0001);
    tick();
    check("br_flag",  64'(cdb_branch),       64'h1);
    check("br_taken", 64'(cdb_branch_taken), 64'h1);
    check("br_tag",   64'(cdb_tag),          64'd5);

    // Flush with mult pending: no grant, valid drops, then mult wins.
    req_valid = 4'b0010;
    flush     = 1'b1;
    #1;
    check("fl_grant", 64'(req_grant), 64'h0);
    tick();
    check("fl_valid",  64'(cdb_valid), 64'h0);
    check("fl_grant2", 64'(req_grant), 64'h0);
    tick();
    flush = 1'b0;
    #1;
    check("fl_after_grant", 64'(req_grant), 64'b0010);
    tick();
    check("fl_after_valid", 64'(cdb_valid), 64'h1);
    check("fl_after_tag",   64'(cdb_tag),   64'd11);
    check("fl_after_br",    64'(cdb_branch), 64'h0);

    // Reset mid-broadcast with all valid; pointer is 2 before reset.
    req_valid = 4'b1111;
    #1;
    check("mid_pre_grant", 64'(req_grant), 64'b0100);
    rst = 1'b0;
    #1;
    check("mid_valid", 64'(cdb_valid), 64'h0);
    check("mid_grant", 64'(req_grant), 64'h0);
    check("mid_data",  64'(cdb_data),  64'h0);
    tick();
    rst = 1'b1;
    #1;
    check("mid_restart", 64'(req_grant), 64'b0001);
    tick();
    check("mid_tag",   64'(cdb_tag),   64'd5);
    check("mid_valid2", 64'(cdb_valid), 64'h1);
    check("mid_next",  64'(req_grant), 64'b0010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
